rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4, number of reset domains; legal range 1..8.
REQ-002 Parameter STRETCH_CYCLES, default 1024, reset hold time after lock is seen; legal range ≥1.
REQ-003 Parameter STAGGER_CYCLES, default 16, spacing between successive channel releases; legal range ≥1.
REQ-004 Parameter DEBOUNCE_CYCLES, default 65000, button stable time; legal range ≥1.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-007 Port rst  input  1  reset, synchronous, active-high.
REQ-008 Port locked  input  1  clock-generator lock; asynchronous to clk.
REQ-009 Port btn  input  1  raw push-button; asynchronous, bouncing, active-high.
REQ-010 Port rst_out  output  NUM_CH  per-domain reset, active-high; bit k is released k-th.
REQ-011 Port ready  output  1  high when all domains are released.
REQ-012 Port state_dbg  output  2  current state: HOLD=0, STRETCH=1, RELEASE=2, RUN=3.

Function
REQ-013 locked and btn SHALL each pass through a 2-FF synchronizer; locked_s and btn_s denote the synchronized values.
REQ-014 btn_ev SHALL be a one-cycle pulse on each rising edge of the debounced button level (see REQ-026/027).
REQ-015 abort SHALL be defined as (locked_s==0) OR btn_ev; in every state, abort moves the FSM to HOLD on the next edge.
  - Simultaneous lock loss and btn_ev cause a single HOLD entry.
REQ-016 HOLD: all rst_out bits 1, ready 0; go to STRETCH when abort==0, clearing the cycle counter.
REQ-017 STRETCH: the counter increments every cycle; at count==STRETCH_CYCLES-1, go to RELEASE with channel index idx=0 and counter cleared.
REQ-018 RELEASE: rst_out[k]=0 for every k≤idx, all others stay 1.
  - The counter runs 0..STAGGER_CYCLES-1.
  - At terminal count: if idx==NUM_CH-1 go to RUN, else increment idx and clear the counter.
REQ-019 RUN: all rst_out bits 0, ready 1; stay in RUN until abort.
REQ-020 rst_out, ready and state_dbg SHALL be registered and reflect the current state, with no combinational path from the inputs.
REQ-021 Timing, with STRETCH entry at cycle 0:
  - rst_out[k] falls at cycle STRETCH_CYCLES + k·STAGGER_CYCLES.
  - ready rises at cycle STRETCH_CYCLES + NUM_CH·STAGGER_CYCLES.
REQ-022 Counter width SHALL be $clog2(max(STRETCH_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES)+1); no counter wraps.
REQ-023 A released channel SHALL never re-assert except through HOLD; in HOLD, all bits re-assert together.

Reset
REQ-024 While rst=1, on each edge:
  - state goes to HOLD; rst_out goes to all ones; ready goes to 0.
  - all counters and idx go to 0; synchronizer flops go to 0; debounced level goes to 0.
REQ-025 After rst falls, sequencing SHALL start only once locked_s==1; a stale lock never skips STRETCH.

Configuration
REQ-026 With RST_SEQ_DEBOUNCE_EN defined, the debounced level SHALL update to btn_s only after btn_s has differed from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-027 Without RST_SEQ_DEBOUNCE_EN:
  - the debounced level SHALL be btn_s directly, so btn_ev is the rising edge of btn_s;
  - the DEBOUNCE_CYCLES parameter is ignored and the debounce counter is not built.

Verification
(all scenarios use NUM_CH=3, STRETCH_CYCLES=8, STAGGER_CYCLES=4, DEBOUNCE_CYCLES=5)
REQ-028 Normal start: locked=1, rst pulsed for 2 cycles, state_dbg becomes 1 at cycle 0 -> rst_out=3'b111 until cycle 8; 3'b110 at 8; 3'b100 at 12; 3'b000 at 16; ready=1 at 20; state_dbg=3 from 20.
REQ-029 Lock loss: locked dropped at cycle 13 of REQ-028 -> after the 2-cycle synchronizer plus 1 edge, rst_out=3'b111, ready=0, state_dbg=0; relock restarts the full 8-cycle stretch.
REQ-030 Button in RUN, macro defined: btn glitches high for 3 cycles -> no effect; btn held high for ≥5 stable cycles -> one btn_ev, HOLD, full resequence; btn held high afterwards -> no second event.
REQ-031 Button, macro undefined: btn high for 1 cycle in RUN -> HOLD 3 cycles later (2 synchronizer + 1 edge), then resequence to ready.
REQ-032 Simultaneous abort: locked falls and btn_ev occur in the same cycle during STRETCH -> exactly one HOLD entry; rst_out stays 3'b111.
REQ-033 Reset mid-RELEASE: rst=1 while rst_out=3'b100 -> next edge gives rst_out=3'b111, ready=0, state_dbg=0, all counters 0.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for clock lock, stretches reset, then releases NUM_CH domains in turn.
// Optional macro RST_SEQ_DEBOUNCE_EN adds a push-button debouncer in front of the abort logic.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   HOLD    | all domains in reset, waiting for lock and no button event
//   STRETCH | lock seen, holding all resets for STRETCH_CYCLES
//   RELEASE | releasing domains 0..idx, one every STAGGER_CYCLES
//   RUN     | all domains released, ready asserted
module rst_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int STRETCH_CYCLES  = 1024,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              btn,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic [1:0]        state_dbg
);

  localparam int MAX_SS  = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int CNT_MAX = (MAX_SS > DEBOUNCE_CYCLES) ? MAX_SS : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [NUM_CH-1:0] rst_out_nxt;
  logic              ready_nxt;

  logic [1:0] lock_sync, btn_sync;
  logic       locked_s, btn_s;
  logic       db_level, db_prev, btn_ev, abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sync <= 2'b00;
      btn_sync  <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], locked};
      btn_sync  <= {btn_sync[0], btn};
    end
  end

  assign locked_s = lock_sync[1];
  assign btn_s    = btn_sync[1];

`ifdef RST_SEQ_DEBOUNCE_EN
  logic [CW-1:0] db_cnt;

  // Level follows btn_s only after an unbroken run of disagreement; any agreement restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_s != db_level) begin
      if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign db_level = btn_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) db_prev <= 1'b0;
    else     db_prev <= db_level;
  end

  assign btn_ev = db_level & ~db_prev;
  assign abort  = ~locked_s | btn_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_out <= rst_out_nxt;
      ready   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (abort) begin
      state_nxt = HOLD;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        HOLD: begin
          state_nxt = STRETCH;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        STRETCH: begin
          if (cnt == CW'(STRETCH_CYCLES - 1)) begin
            state_nxt = RELEASE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGGER_CYCLES - 1)) begin
            cnt_nxt = '0;
            if (idx == IW'(NUM_CH - 1)) state_nxt = RUN;
            else                        idx_nxt   = idx + IW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN: begin
          cnt_nxt = '0;
        end
        default: begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state.
  always_comb begin
    rst_out_nxt = '1;
    ready_nxt   = 1'b0;
    case (state_nxt)
      RELEASE: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (IW'(k) <= idx_nxt) rst_out_nxt[k] = 1'b0;
        end
      end
      RUN: begin
        rst_out_nxt = '0;
        ready_nxt   = 1'b1;
      end
      default: begin
        rst_out_nxt = '1;
        ready_nxt   = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with NUM_CH=3, STRETCH=8, STAGGER=4, DEBOUNCE=5.
// Button scenarios follow RST_SEQ_DEBOUNCE_EN when it is defined for the build.
module tb_rst_sequencer;
  localparam int NCH = 3;
  localparam int ST  = 8;
  localparam int SG  = 4;
  localparam int DB  = 5;
`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int BTN_LAT = 8;
`else
  localparam int BTN_LAT = 3;
`endif

  logic           clk = 1'b0;
  logic           rst, locked, btn;
  logic [NCH-1:0] rst_out;
  logic           ready;
  logic [1:0]     state_dbg;
  int n_cmp = 0;
  int n_err = 0;

  rst_sequencer #(
    .NUM_CH(NCH), .STRETCH_CYCLES(ST), .STAGGER_CYCLES(SG), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .btn(btn),
    .rst_out(rst_out), .ready(ready), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stretch(input int budget);
    int c = 0;
    while (state_dbg !== 2'd1 && c < budget) begin
      step();
      c++;
    end
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_err++;
      $display("FAIL wait_stretch: state=%0d after %0d cycles, want 1", state_dbg, c);
    end
    n_cmp++;
    if (rst_out !== 3'b111 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL stretch_entry: rst_out=%b ready=%b, want 111 0", rst_out, ready);
    end
  endtask

  task automatic check_sequence(input int first, input int last);
    logic [2:0] er;
    logic       erdy;
    logic [1:0] est;
    for (int n = first; n <= last; n++) begin
      step();
      erdy = 1'b0;
      if (n < ST)               begin er = 3'b111; est = 2'd1; end
      else if (n < ST + SG)     begin er = 3'b110; est = 2'd2; end
      else if (n < ST + 2*SG)   begin er = 3'b100; est = 2'd2; end
      else if (n < ST + 3*SG)   begin er = 3'b000; est = 2'd2; end
      else begin er = 3'b000; est = 2'd3; erdy = 1'b1; end
      n_cmp++;
      if (rst_out !== er || ready !== erdy || state_dbg !== est) begin
        n_err++;
        $display("FAIL seq_cycle_%0d: rst_out=%b ready=%b state=%0d, want %b %b %0d",
                 n, rst_out, ready, state_dbg, er, erdy, est);
      end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; btn = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (rst_out !== 3'b111 || ready !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: rst_out=%b ready=%b state=%0d, want 111 0 0", rst_out, ready, state_dbg);
    end
    locked = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (state_dbg !== 2'd0 || rst_out !== 3'b111) begin
      n_err++;
      $display("FAIL reset_with_lock: state=%0d rst_out=%b, want 0 111", state_dbg, rst_out);
    end
  endtask

  task automatic test_normal();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (state_dbg !== 2'd0) begin
        n_err++;
        $display("FAIL stale_lock_%0d: state=%0d, want 0", i, state_dbg);
      end
    end
    step();
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_err++;
      $display("FAIL stretch_start: state=%0d, want 1", state_dbg);
    end
    check_sequence(1, 24);
  endtask

  task automatic test_lock_loss();
    pulse_rst();
    wait_stretch(20);
    check_sequence(1, 13);
    locked = 1'b0;
    for (int i = 14; i <= 15; i++) begin
      step();
      n_cmp++;
      if (state_dbg !== 2'd2 || rst_out !== 3'b100) begin
        n_err++;
        $display("FAIL lockloss_sync_%0d: state=%0d rst_out=%b, want 2 100", i, state_dbg, rst_out);
      end
    end
    step();
    n_cmp++;
    if (state_dbg !== 2'd0 || rst_out !== 3'b111 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL lockloss_hold: state=%0d rst_out=%b ready=%b, want 0 111 0", state_dbg, rst_out, ready);
    end
    locked = 1'b1;
    wait_stretch(20);
    check_sequence(1, 24);
  endtask

  task automatic test_reset_mid_release();
    pulse_rst();
    wait_stretch(20);
    check_sequence(1, 12);
    rst = 1'b1;
    step();
    n_cmp++;
    if (rst_out !== 3'b111 || ready !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++;
      $display("FAIL mid_release_reset: rst_out=%b ready=%b state=%0d, want 111 0 0", rst_out, ready, state_dbg);
    end
    rst = 1'b0;
    wait_stretch(20);
    check_sequence(1, 24);
  endtask

`ifdef RST_SEQ_DEBOUNCE_EN
  task automatic test_button();
    btn = 1'b1;
    repeat (3) step();
    btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      n_cmp++;
      if (state_dbg !== 2'd3) begin
        n_err++;
        $display("FAIL btn_glitch_%0d: state=%0d, want 3", i, state_dbg);
      end
    end
    btn = 1'b1;
    for (int i = 1; i <= BTN_LAT; i++) begin
      step();
      n_cmp++;
      if (state_dbg !== ((i < BTN_LAT) ? 2'd3 : 2'd0)) begin
        n_err++;
        $display("FAIL btn_debounced_%0d: state=%0d", i, state_dbg);
      end
    end
    wait_stretch(20);
    check_sequence(1, 24);
    for (int i = 0; i < 30; i++) begin
      step();
      n_cmp++;
      if (state_dbg !== 2'd3) begin
        n_err++;
        $display("FAIL btn_held_%0d: state=%0d, want 3", i, state_dbg);
      end
    end
    btn = 1'b0;
    repeat (12) step();
    n_cmp++;
    if (state_dbg !== 2'd3 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL btn_release: state=%0d ready=%b, want 3 1", state_dbg, ready);
    end
  endtask
`else
  task automatic test_button();
    btn = 1'b1;
    step();
    btn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) step();
      n_cmp++;
      if (state_dbg !== ((i < 3) ? 2'd3 : 2'd0)) begin
        n_err++;
        $display("FAIL btn_raw_%0d: state=%0d", i, state_dbg);
      end
    end
    n_cmp++;
    if (rst_out !== 3'b111 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL btn_raw_hold: rst_out=%b ready=%b, want 111 0", rst_out, ready);
    end
    wait_stretch(20);
    check_sequence(1, 24);
  endtask
`endif

  task automatic test_simultaneous();
    int holds = 0;
    int bad_rst = 0;
    logic [1:0] prev;
    pulse_rst();
    wait_stretch(20);
    prev = state_dbg;
    btn = 1'b1;
    for (int i = 1; i <= BTN_LAT + 6; i++) begin
      if (i == BTN_LAT - 2) locked = 1'b0;
      step();
      if (state_dbg === 2'd0 && prev !== 2'd0) holds++;
      if (rst_out !== 3'b111) bad_rst++;
      if (i == BTN_LAT) begin
        n_cmp++;
        if (state_dbg !== 2'd0) begin
          n_err++;
          $display("FAIL simul_hold_time: state=%0d, want 0", state_dbg);
        end
      end
      prev = state_dbg;
    end
    n_cmp++;
    if (holds != 1) begin
      n_err++;
      $display("FAIL simul_hold_entries: got %0d, want 1", holds);
    end
    n_cmp++;
    if (bad_rst != 0) begin
      n_err++;
      $display("FAIL simul_rst_out: %0d cycles not 111, want 0", bad_rst);
    end
    btn = 1'b0;
    locked = 1'b1;
    wait_stretch(20);
    check_sequence(1, 24);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_lock_loss();
    test_button();
    test_simultaneous();
    test_reset_mid_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
